// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush sequencer.
//   ctrl_state_e : sequencer state (IDLE / EX_BUSY)
//   STALL_*      : stall vector encodings, bit0 PC .. bit5 WB, 1 = hold
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_FROM_ID = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_FROM_EX = 6'b001111;

  typedef enum logic {
    CTRL_IDLE    = 1'b0,
    CTRL_EX_BUSY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
//   master : pipeline side, raises stallreq_id_i / ex_start_i+ex_cycles_i /
//            flush_req_i and receives the stall vector and status strobes.
//   slave  : pipe_ctrl side.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
);
  logic               stallreq_id_i;
  logic               ex_start_i;
  logic [CNT_W-1:0]   ex_cycles_i;
  logic               flush_req_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_o;
  logic               ex_done_o;
  logic               ex_abort_o;
  logic               busy_o;

  modport master (
    output stallreq_id_i, ex_start_i, ex_cycles_i, flush_req_i,
    input  stall_o, flush_o, ex_done_o, ex_abort_o, busy_o
  );

  modport slave (
    input  stallreq_id_i, ex_start_i, ex_cycles_i, flush_req_i,
    output stall_o, flush_o, ex_done_o, ex_abort_o, busy_o
  );
endinterface

// File: rtl/pipe_busy_cnt.sv
// Loadable CNT_W-bit down-counter tracking the remaining EX multi-cycle
// stall cycles. Stops at zero (no wrap-around).
//   clk, rst   : clock, asynchronous active-low reset
//   load_i     : load load_val_i
//   load_val_i : value to load
//   dec_i      : decrement (ignored at zero)
//   clr_i      : force to zero, highest priority
//   zero_o     : counter is zero
module pipe_busy_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the PC/IF/ID/EX/MEM/WB pipeline.
// Merges the decode load-use stall, EX multi-cycle ops and exception
// flushes into one stall vector plus a flush strobe.
// Priority: flush > EX multi-cycle > decode load-use.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : pipe_ctrl_if.slave (requests in, stall/flush/status out)
// Optional (macro PIPE_CTRL_STATS_EN):
//   stats_clr_i : clear the stall-cycle counter (beats increment)
//   stall_cyc_o : saturating count of cycles with a nonzero stall vector
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_if.slave        bus
`ifdef PIPE_CTRL_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [31:0]       stall_cyc_o
`endif
);

  ctrl_state_e        state_q, state_d;
  logic [STALL_W-1:0] stall;
  logic               flush, ex_done, ex_abort, busy;
  logic               cnt_load, cnt_dec, cnt_clr, cnt_zero;
  logic [CNT_W-1:0]   n_cycles;

  assign n_cycles = bus.ex_cycles_i;

  // The start cycle and the final (cnt==0) cycle are both stall cycles,
  // so an N-cycle op loads N-3 to get N-1 stall cycles in total.
  pipe_busy_cnt #(.CNT_W(CNT_W)) u_busy_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (n_cycles - CNT_W'(3)),
    .dec_i      (cnt_dec),
    .clr_i      (cnt_clr),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    stall    = STALL_NONE;
    flush    = 1'b0;
    ex_done  = 1'b0;
    ex_abort = 1'b0;
    busy     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        if (bus.flush_req_i) begin
          flush = 1'b1;
        end else if (bus.ex_start_i) begin
          if (n_cycles <= CNT_W'(1)) begin
            ex_done = 1'b1;
          end else if (n_cycles == CNT_W'(2)) begin
            stall   = STALL_FROM_EX;
            ex_done = 1'b1;
          end else begin
            stall    = STALL_FROM_EX;
            cnt_load = 1'b1;
            state_d  = CTRL_EX_BUSY;
          end
        end else if (bus.stallreq_id_i) begin
          stall = STALL_FROM_ID;
        end
      end
      CTRL_EX_BUSY: begin
        busy = 1'b1;
        // Decode stall and new EX starts cannot occur while EX is held.
        if (bus.flush_req_i) begin
          flush    = 1'b1;
          ex_abort = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = CTRL_IDLE;
        end else begin
          stall = STALL_FROM_EX;
          if (cnt_zero) begin
            ex_done = 1'b1;
            state_d = CTRL_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Async reset also forces the combinational outputs low immediately.
  assign bus.stall_o    = rst ? stall    : STALL_NONE;
  assign bus.flush_o    = rst & flush;
  assign bus.ex_done_o  = rst & ex_done;
  assign bus.ex_abort_o = rst & ex_abort;
  assign bus.busy_o     = rst & busy;

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (stats_clr_i) begin
      stall_cyc_d = '0;
    end else if ((stall != STALL_NONE) && (stall_cyc_q != 32'hFFFF_FFFF)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign stall_cyc_o = stall_cyc_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic, all checked against a remaining-stall-cycles reference model.
module tb_pipe_ctrl;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

`ifdef PIPE_CTRL_STATS_EN
  logic        stats_clr;
  logic [31:0] stall_cyc;
`endif

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .stats_clr_i (stats_clr),
    .stall_cyc_o (stall_cyc)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: number of EX stall cycles still owed after the
  // current cycle by an in-flight op (0 = no op in flight).
  int     ex_rem = 0;
  longint stat_m = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic sreq, input logic start, input int n, input logic fl,
                       input logic clr);
    bus.stallreq_id_i = sreq;
    bus.ex_start_i    = start;
    bus.ex_cycles_i   = CNT_W'(n);
    bus.flush_req_i   = fl;
`ifdef PIPE_CTRL_STATS_EN
    stats_clr = clr;
`else
    if (clr) begin end
`endif
  endtask

  // One cycle: drive at negedge, compare mid-cycle, then advance the model.
  task automatic step(input logic sreq, input logic start, input int n, input logic fl,
                      input logic clr);
    logic [5:0] e_stall;
    logic       e_fl, e_done, e_abort, e_busy;
    int         nxt;
    @(negedge clk);
    drive(sreq, start, n, fl, clr);
    #1;
    e_stall = 6'b0; e_fl = 0; e_done = 0; e_abort = 0; e_busy = 0;
    nxt = ex_rem;
    if (ex_rem > 0) begin
      e_busy = 1;
      if (fl) begin
        e_fl = 1; e_abort = 1; nxt = 0;
      end else begin
        e_stall = 6'b001111;
        e_done  = (ex_rem == 1);
        nxt     = ex_rem - 1;
      end
    end else if (fl) begin
      e_fl = 1;
    end else if (start) begin
      // An N-cycle op stalls N-1 cycles; the first is this cycle.
      if (n >= 2) e_stall = 6'b001111;
      if (n <= 2) e_done = 1;
      else        nxt = n - 2;
    end else if (sreq) begin
      e_stall = 6'b000111;
    end
    check_val("stall_o",    32'(bus.stall_o),    32'(e_stall));
    check_val("flush_o",    32'(bus.flush_o),    32'(e_fl));
    check_val("ex_done_o",  32'(bus.ex_done_o),  32'(e_done));
    check_val("ex_abort_o", 32'(bus.ex_abort_o), 32'(e_abort));
    check_val("busy_o",     32'(bus.busy_o),     32'(e_busy));
    check_val("flush_vs_stall", 32'(bus.flush_o && (bus.stall_o != 6'b0)), 32'd0);
`ifdef PIPE_CTRL_STATS_EN
    check_val("stall_cyc_o", stall_cyc, 32'(stat_m));
    if (clr) stat_m = 0;
    else if (e_stall != 6'b0 && stat_m < 64'hFFFF_FFFF) stat_m++;
`endif
    ex_rem = nxt;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, 63, 1, 1);

    // Reset held with every input high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_val("rst_stall", 32'(bus.stall_o), 32'd0);
      check_val("rst_flush", 32'(bus.flush_o), 32'd0);
      check_val("rst_busy",  32'(bus.busy_o),  32'd0);
      check_val("rst_done",  32'(bus.ex_done_o), 32'd0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    idle(2);

    // Load-use for two cycles.
    step(1, 0, 0, 0, 0);
    check_val("lu_stall1", 32'(bus.stall_o), 32'h07);
    step(1, 0, 0, 0, 0);
    check_val("lu_stall2", 32'(bus.stall_o), 32'h07);
    step(0, 0, 0, 0, 0);
    check_val("lu_after", 32'(bus.stall_o), 32'h00);

    // N=5: four stall cycles, done in the 4th, busy in 2..4.
    step(0, 1, 5, 0, 0);
    check_val("n5_c1", {bus.busy_o, bus.ex_done_o, 24'd0, bus.stall_o}, {2'b00, 24'd0, 6'h0f});
    for (int c = 2; c <= 4; c++) begin
      step(0, 0, 0, 0, 0);
      check_val("n5_cx", {bus.busy_o, bus.ex_done_o, 24'd0, bus.stall_o},
                {1'b1, (c == 4), 24'd0, 6'h0f});
    end
    step(0, 0, 0, 0, 0);
    check_val("n5_end", 32'(bus.stall_o), 32'd0);

`ifdef PIPE_CTRL_STATS_EN
    check_val("stats_6", stall_cyc, 32'd6);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_val("stats_clr", stall_cyc, 32'd0);
`endif

    // N=2, N=1, N=0.
    step(0, 1, 2, 0, 0);
    check_val("n2_done", {31'd0, bus.ex_done_o}, 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check_val("n1_stall", 32'(bus.stall_o), 32'd0);
    step(0, 1, 0, 0, 0);

    // EX start beats load-use; load-use shows once EX is done.
    step(1, 1, 4, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_val("prio_lu", 32'(bus.stall_o), 32'h07);
    step(0, 0, 0, 0, 0);

    // Flush kills an N=10 op in its 3rd stall cycle.
    step(0, 1, 10, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check_val("abort", {30'd0, bus.flush_o, bus.ex_abort_o}, 32'd3);
    idle(3);

    // Flush in IDLE overrides a start.
    step(1, 1, 7, 1, 0);
    idle(1);

    // Asynchronous reset mid-op drops outputs without a clock edge.
    step(0, 1, 12, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_val("pre_arst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b0;
    #1;
    check_val("arst_stall", 32'(bus.stall_o), 32'd0);
    check_val("arst_busy",  32'(bus.busy_o),  32'd0);
    ex_rem = 0;
    stat_m = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic sreq, start, fl, clr;
      int   n;
      sreq  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 11) == 0);
      clr   = ($urandom_range(0, 40) == 0);
      n     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63))
                                          : int'($urandom_range(0, 6));
      step(sreq, start, n, fl, clr);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: PC, IF, ID, EX, MEM, WB.
- Takes the load-use stall request raised by the decode stage, the multi-cycle start from EX (mult/div/madd), and the exception flush request.
- Drives one stall vector to all pipeline registers and the PC, plus a flush strobe.
- Sits at the top level beside the pipeline registers.

Parameters:
- CNT_W, 6, width of the EX multi-cycle length field; max op length 2^CNT_W-1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id_i  in  1  decode load-use hazard; combinational, same-cycle.
- ex_start_i  in  1  one-cycle pulse: EX begins a multi-cycle op.
- ex_cycles_i  in  CNT_W  total EX cycles of that op; sampled with ex_start_i.
- flush_req_i  in  1  exception/eret flush request.
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush_o  out  1  clear all pipeline registers this cycle.
- ex_done_o  out  1  pulse in the final stall cycle of a multi-cycle op.
- ex_abort_o  out  1  pulse when a flush kills an in-flight multi-cycle op.
- busy_o  out  1  state is EX_BUSY.

Behaviour:
- Reset is asynchronous and active-low. While rst=0:
  - state=IDLE, cnt=0.
  - stall_o=6'b000000; flush_o, ex_done_o, ex_abort_o, busy_o all 0.
  - Every output holds this value one clk edge after rst deasserts.
- States: IDLE, EX_BUSY. cnt is a CNT_W-bit down-counter. All outputs are combinational from (state, cnt, inputs).
- Priority: flush_req_i > EX multi-cycle > stallreq_id_i.
- IDLE, flush_req_i=1:
  - flush_o=1, stall_o=0, next state IDLE.
  - ex_start_i is ignored, because the op is killed.
- IDLE, ex_start_i=1, N=ex_cycles_i:
  - N<=1: no stall; state stays IDLE; ex_done_o=1 this cycle.
  - N=2: stall_o=6'b001111 for this cycle only; ex_done_o=1; state stays IDLE.
  - N>=3: stall_o=6'b001111; cnt<=N-3; next state EX_BUSY.
  - Total stall cycles = N-1 in all cases.
- IDLE, stallreq_id_i=1 with no higher request:
  - stall_o=6'b000111; no state change.
  - Re-evaluated every cycle, so it stalls for as long as the request is held.
- EX_BUSY:
  - stall_o=6'b001111, busy_o=1.
  - stallreq_id_i and ex_start_i are ignored; both are illegal while EX is held.
  - cnt!=0: cnt decrements.
  - cnt==0: ex_done_o=1; next state IDLE.
- EX_BUSY with flush_req_i=1:
  - flush_o=1, ex_abort_o=1, stall_o=0.
  - cnt<=0; next state IDLE.
  - ex_done_o is not asserted.
- flush_o and a nonzero stall_o are never asserted in the same cycle.
- No wrap-around: cnt only loads on an IDLE-to-EX_BUSY transition and stops at 0.
- Asynchronous reset mid-EX_BUSY: state returns to IDLE and all outputs drop to 0 immediately, without waiting for clk.

Optional Feature:
- Macro: PIPE_CTRL_STATS_EN.
- Defined:
  - Adds input stats_clr_i (1) and output stall_cyc_o (32).
  - stall_cyc_o increments each cycle stall_o!=0 and saturates at 32'hFFFFFFFF.
  - stats_clr_i=1 loads 0; clear has priority over increment.
  - Reset value 0.
- Undefined: neither port exists and no counter logic is built; all other behaviour is identical.

Decomposition:
- defines.v gets:
  - `StallBus 5:0.
  - Stall encodings `StallNone 6'b000000, `StallFromId 6'b000111, `StallFromEx 6'b001111.
  - State encodings `CtrlIdle, `CtrlExBusy.
- One natural sub-module: pipe_busy_cnt, the loadable CNT_W down-counter with zero flag.
- The FSM and output decode stay in pipe_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all inputs 1 -> stall_o=0, flush_o=0, busy_o=0. Release rst -> IDLE; all outputs still 0 on the next edge.
- Load-use: stallreq_id_i=1 for 2 cycles -> stall_o=6'b000111 for exactly those 2 cycles, then 0. busy_o stays 0.
- Multi-cycle lengths:
  - ex_start_i with ex_cycles_i=5 -> stall_o=6'b001111 for 4 consecutive cycles; ex_done_o=1 only in the 4th; busy_o=1 in cycles 2-4.
  - ex_cycles_i=2 -> 1 stall cycle with ex_done_o.
  - ex_cycles_i=1 -> 0 stall cycles; ex_done_o in the start cycle.
- Priority: ex_start_i=1 (N=4) and stallreq_id_i=1 together -> stall_o=6'b001111. stallreq_id_i held throughout -> EX stall persists for 3 cycles; in cycle 4 (IDLE) stall_o=6'b000111.
- Flush abort: ex_cycles_i=10, flush_req_i=1 in the 3rd stall cycle -> that cycle flush_o=1, ex_abort_o=1, stall_o=0. Next cycle IDLE; ex_done_o never pulses.
- Stats (PIPE_CTRL_STATS_EN): run the sequence above -> stall_cyc_o=2+4 = 6. Pulse stats_clr_i together with a stall cycle -> stall_cyc_o=0.
